octal_rr_arbiter: RTL
=====================

// Module: octal_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource between 8 requesters. Selects one
//  requester, holds the grant until release or timeout, then rotates priority.
//  Emits a one-hot grant and its octal-to-binary encoded index (3 bits) so
//  downstream muxes can be steered directly.
// PARAMETERS
//  N_REQ     8   number of requesters (fixed at 8; index width is 3)
//  IDX_W     3   width of encoded grant index, log2(N_REQ)
//  MAX_HOLD  16  max cycles a grant may be held; 0 disables the watchdog
//  CNT_W     5   hold-counter width; must hold MAX_HOLD
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  req        in   8      request vector; bit i = requester i wants the resource
//  done       in   1      grantee finished; releases grant (ignored if !gnt_valid)
//  gnt        out  8      one-hot grant, all-zero when idle
//  gnt_idx    out  3      binary index of the set gnt bit; 0 when idle
//  gnt_valid  out  1      high while a grant is active
//  timeout    out  1      one-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  Reset (rst=1 at edge): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//   ptr=0 (req[0] highest priority), hold_cnt=0, state=IDLE. Reset
//   mid-grant drops the grant on the same edge; done is not required.
//  All outputs registered; no combinational path from inputs to outputs.
//  States: IDLE, GRANT.
//  IDLE: if req!=0, choose first set bit scanning ptr, ptr+1, ... ptr+7 mod 8
//   (wrap 7->0). Next edge: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1,
//   hold_cnt=0, state=GRANT. Latency: req asserted at edge k -> gnt at k+1.
//   If req==0, stay in IDLE and keep outputs zero.
//  GRANT: hold_cnt increments each cycle and saturates at MAX_HOLD-1.
//   Release conditions, checked each edge:
//   (a) done=1, or (b) req[gnt_idx]=0 (requester withdrew), or
//   (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with neither (a) nor (b).
//   On release: gnt=0, gnt_idx=0, gnt_valid=0, ptr=(gnt_idx+1) mod 8,
//   state=IDLE. Case (c) also sets timeout=1 for exactly one cycle.
//   Without release: the grant is unchanged; other req bits are ignored.
//  One mandatory idle cycle between consecutive grants (fairness and turnaround).
//  Grant lengths: max MAX_HOLD cycles with gnt_valid=1 per grant.
//  Priority on release: done/withdraw beat timeout in the same cycle
//   (no timeout pulse).
//  Invariants: gnt is zero or one-hot; gnt_idx==encode(gnt); gnt_valid==|gnt.
//  X on req or done during reset is ignored.
// TESTING
//  1 Reset: rst=1 2 cycles with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0,
//    timeout=0; rst=0 -> next edge gnt=8'h01, gnt_idx=0.
//  2 Rotation: req=8'hFF held, pulse done 1 cycle after each grant ->
//    gnt sequence 01,02,04,08,10,20,40,80,01 with gnt_idx 0..7,0;
//    one idle cycle between grants.
//  3 Wrap/skip: ptr=6 (after grant 5), req=8'b0000_1001 -> gnt=8'h01
//    (idx 0), then after done -> gnt=8'h08 (idx 3).
//  4 Timeout: MAX_HOLD=16, req=8'h04 held, done=0 -> gnt_valid high exactly
//    16 cycles, timeout 1-cycle pulse at drop, next grant 8'h04 after idle.
//  5 Withdraw/simultaneous: granted idx 2, drop req[2] and raise done on
//    cycle 15 -> release, no timeout; ptr=3.
//  6 Reset mid-grant: rst=1 while gnt=8'h20 -> next edge outputs zero,
//    ptr=0; next grant goes to the lowest set req bit.

Source files
------------

// File: rtl/octal_rr_arbiter.sv
// Eight-way round-robin arbiter: one grant at a time, held until done, withdraw
// or watchdog expiry, with the search pointer rotated past the last grantee.
module octal_rr_arbiter #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   // Last value the hold counter may take; also its saturation point.
   localparam logic [CNT_W-1:0] CNT_LAST =
      (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   state_t           state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [CNT_W-1:0] hold_cnt_reg;

   logic [N_REQ-1:0] rot_req;
   logic [IDX_W-1:0] off_next;
   logic [IDX_W-1:0] sel_next;
   logic             withdraw;
   logic             expire;

   // Request vector rotated so that bit 0 is the requester at ptr_reg.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign rot_req[gi] = req[ptr_reg + IDX_W'(gi)];
      end
   endgenerate

   always_comb begin
      off_next = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot_req[i]) off_next = IDX_W'(i);
      end
   end

   assign sel_next = ptr_reg + off_next;
   assign withdraw = !req[gnt_idx];
   assign expire   = (MAX_HOLD != 0) && (hold_cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         hold_cnt_reg <= '0;
         gnt          <= '0;
         gnt_idx      <= '0;
         gnt_valid    <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               timeout <= 1'b0;
               if (|req) begin
                  state_reg    <= GRANT;
                  gnt          <= ONE_HOT0 << sel_next;
                  gnt_idx      <= sel_next;
                  gnt_valid    <= 1'b1;
                  hold_cnt_reg <= '0;
               end
            end
            GRANT: begin
               if (done || withdraw || expire) begin
                  state_reg    <= IDLE;
                  ptr_reg      <= gnt_idx + 1'b1;
                  gnt          <= '0;
                  gnt_idx      <= '0;
                  gnt_valid    <= 1'b0;
                  hold_cnt_reg <= '0;
                  // A voluntary release in the same cycle suppresses the pulse.
                  timeout      <= !(done || withdraw);
               end else if (hold_cnt_reg != CNT_LAST) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
